// File: rtl/score_keeper_pkg.sv
// Shared types and helpers for the buzzer scoring path: FSM states, score defaults,
// and a one-hot decoder that is also used by the responder and display blocks.
package score_keeper_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_JUDGE, APPLY} state_t;

    localparam int SCORE_MAX_DEF  = 99;
    localparam int INIT_SCORE_DEF = 10;
    localparam int OH_W           = 16;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } oh_idx_t;

    // valid only when exactly one bit is set; idx is that bit's position
    function automatic oh_idx_t onehot_to_idx(input logic [OH_W-1:0] oh);
        oh_idx_t r;
        int      cnt;
        r.valid = 1'b0;
        r.idx   = '0;
        cnt     = 0;
        for (int i = 0; i < OH_W; i++) begin
            if (oh[i]) begin
                cnt   = cnt + 1;
                r.idx = 4'(i);
            end
        end
        r.valid = (cnt == 1);
        return r;
    endfunction

endpackage

// File: rtl/score_keeper_leader_finder.sv
// Combinational search over the flattened scores for the maximum; the lowest index wins ties.
// Pure logic, no latency; the caller registers the result.
module leader_finder #(
    parameter int NUM_PLAYERS = 4,
    parameter int SCORE_W     = 7,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_PLAYERS*SCORE_W-1:0] scores_flat,
    output logic [IDX_W-1:0]               idx
);

    logic [SCORE_W-1:0] best;

    always_comb begin
        best = scores_flat[0 +: SCORE_W];
        idx  = '0;
        // strict greater-than keeps the earlier index on equal scores
        for (int i = 1; i < NUM_PLAYERS; i++) begin
            if (scores_flat[i*SCORE_W +: SCORE_W] > best) begin
                best = scores_flat[i*SCORE_W +: SCORE_W];
                idx  = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Applies compere judgements to the buzzing player's saturating score and tracks the leader.
// Optional TIMEOUT_PENALTY_EN: a timer expiry while awaiting judgement is scored as a wrong answer.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int SCORE_W     = 7,
    parameter int SCORE_MAX   = SCORE_MAX_DEF,
    parameter int INIT_SCORE  = INIT_SCORE_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           startgame,
    input  logic                           stoptimer,
    input  logic [NUM_PLAYERS-1:0]         who,
    input  logic [3:0]                     maxuser,
    input  logic                           yes,
    input  logic                           no,
    input  logic                           endtime,
    input  logic [3:0]                     scorejia,
    input  logic [3:0]                     scorejian,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic [1:0]                     cur_player,
    output logic                           busy,
    output logic                           result_valid,
    output logic                           result_ok,
    output logic [1:0]                     leader,
    output logic                           err
);

    state_t             state_q, state_d;
    logic [1:0]         cur_q, cur_d;
    logic               add_q, add_d;
    logic [3:0]         amt_q, amt_d;
    logic               err_q, err_d;
    logic [1:0]         leader_q, leader_d;
    logic [SCORE_W-1:0] score_q [NUM_PLAYERS];
    logic [SCORE_W-1:0] score_d [NUM_PLAYERS];

    oh_idx_t            who_dec;
    logic               who_ok;
    logic [SCORE_W:0]   cur_ext, sum_ext, diff_ext;
    logic [SCORE_W-1:0] apply_val;

    assign who_dec = onehot_to_idx(OH_W'(who));
    assign who_ok  = who_dec.valid && (who_dec.idx < maxuser);

    // one extra bit so overflow and borrow are visible before clamping
    assign cur_ext  = {1'b0, score_q[cur_q]};
    assign sum_ext  = cur_ext + (SCORE_W+1)'(amt_q);
    assign diff_ext = cur_ext - (SCORE_W+1)'(amt_q);

    always_comb begin
        if (add_q)
            apply_val = (sum_ext > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                             : sum_ext[SCORE_W-1:0];
        else
            apply_val = diff_ext[SCORE_W] ? '0 : diff_ext[SCORE_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        add_d   = add_q;
        amt_d   = amt_q;
        err_d   = 1'b0;
        score_d = score_q;
        case (state_q)
            IDLE: begin
                if (stoptimer) begin
                    if (who_ok) begin
                        cur_d   = who_dec.idx[1:0];
                        state_d = WAIT_JUDGE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT_JUDGE: begin
                if (yes && no) begin
                    err_d = 1'b1;
                end else if (yes) begin
                    add_d   = 1'b1;
                    amt_d   = scorejia;
                    state_d = APPLY;
                end else if (no) begin
                    add_d   = 1'b0;
                    amt_d   = scorejian;
                    state_d = APPLY;
                end else if (endtime) begin
`ifdef TIMEOUT_PENALTY_EN
                    add_d   = 1'b0;
                    amt_d   = scorejian;
                    state_d = APPLY;
`else
                    state_d = IDLE;
`endif
                end
            end
            APPLY: begin
                score_d[cur_q] = apply_val;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (startgame) begin
            state_d = IDLE;
            add_d   = 1'b0;
            err_d   = 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++)
                score_d[i] = SCORE_W'(INIT_SCORE);
        end
    end

    leader_finder #(
        .NUM_PLAYERS(NUM_PLAYERS),
        .SCORE_W    (SCORE_W),
        .IDX_W      (2)
    ) u_leader_finder (
        .scores_flat(scores),
        .idx        (leader_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            add_q    <= 1'b0;
            amt_q    <= '0;
            err_q    <= 1'b0;
            leader_q <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++)
                score_q[i] <= SCORE_W'(INIT_SCORE);
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            add_q    <= add_d;
            amt_q    <= amt_d;
            err_q    <= err_d;
            leader_q <= leader_d;
            score_q  <= score_d;
        end
    end

    for (genvar k = 0; k < NUM_PLAYERS; k++) begin : g_flat
        assign scores[k*SCORE_W +: SCORE_W] = score_q[k];
    end

    assign cur_player   = cur_q;
    assign busy         = (state_q == WAIT_JUDGE);
    assign result_valid = (state_q == APPLY);
    assign result_ok    = add_q;
    assign leader       = leader_q;
    assign err          = err_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed and randomized bench for score_keeper against an arithmetic scoring model.
module tb_score_keeper;

    localparam int NP = 4;
    localparam int SW = 7;
`ifdef TIMEOUT_PENALTY_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, startgame, stoptimer, yes, no, endtime;
    logic [3:0]    who, maxuser, scorejia, scorejian;
    logic [NP*SW-1:0] scores;
    logic [1:0]    cur_player, leader;
    logic          busy, result_valid, result_ok, err;

    int n_cmp = 0;
    int n_mis = 0;
    int mscore [NP];

    always #5 clk = ~clk;

    score_keeper dut (
        .clk(clk), .rst(rst), .startgame(startgame), .stoptimer(stoptimer),
        .who(who), .maxuser(maxuser), .yes(yes), .no(no), .endtime(endtime),
        .scorejia(scorejia), .scorejian(scorejian), .scores(scores),
        .cur_player(cur_player), .busy(busy), .result_valid(result_valid),
        .result_ok(result_ok), .leader(leader), .err(err)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int score_of(input int k);
        return int'(scores[k*SW +: SW]);
    endfunction

    function automatic int model_leader();
        int b = 0;
        for (int k = 1; k < NP; k++)
            if (mscore[k] > mscore[b]) b = k;
        return b;
    endfunction

    function automatic int sat(input int s, input int amt, input bit add);
        int r;
        r = add ? s + amt : s - amt;
        if (r > 99) r = 99;
        if (r < 0)  r = 0;
        return r;
    endfunction

    task automatic check_scores(input string tag);
        for (int k = 0; k < NP; k++)
            check($sformatf("%s_score%0d", tag, k), score_of(k), mscore[k]);
    endtask

    // kind: 0 yes, 1 no, 2 endtime, 3 yes+no then yes
    task automatic do_round(input logic [3:0] w, input logic [3:0] mu,
                            input logic [3:0] jia, input logic [3:0] jian, input int kind);
        int idx = 0;
        bit valid, applies, add;
        for (int i = 0; i < NP; i++) if (w[i]) idx = i;
        valid = ($countones(w) == 1) && (idx < int'(mu));
        who = w; maxuser = mu; scorejia = jia; scorejian = jian;
        stoptimer = 1'b1;
        step();
        stoptimer = 1'b0;
        who = 4'($urandom);
        if (!valid) begin
            check("err_invalid", err, 1);
            check("busy_invalid", busy, 0);
            step();
            check("err_one_pulse", err, 0);
            check("busy_after_invalid", busy, 0);
            check_scores("invalid");
            return;
        end
        check("busy_rise", busy, 1);
        check("err_quiet", err, 0);
        check("cur_player", cur_player, idx);
        maxuser = 4'd1;
        if (kind == 3) begin
            yes = 1'b1; no = 1'b1; stoptimer = 1'b1;
            step();
            yes = 1'b0; no = 1'b0; stoptimer = 1'b0;
            check("err_yes_no", err, 1);
            check("busy_hold_yes_no", busy, 1);
            check("rv_yes_no", result_valid, 0);
            kind = 0;
        end
        yes = (kind == 0);
        no = (kind == 1);
        endtime = (kind == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        step();
        yes = 1'b0; no = 1'b0; endtime = 1'b0;
        add = (kind == 0);
        applies = (kind != 2) || TO_EN;
        check("err_judge", err, 0);
        check("busy_fall", busy, 0);
        if (applies) begin
            check("rv_pulse", result_valid, 1);
            check("result_ok", result_ok, int'(add));
            step();
            check("rv_end", result_valid, 0);
            mscore[idx] = sat(mscore[idx], int'(add ? jia : jian), add);
            check_scores("apply");
            step();
            check("leader", leader, model_leader());
        end else begin
            check("rv_timeout", result_valid, 0);
            step();
            check("rv_timeout2", result_valid, 0);
            check_scores("timeout");
        end
    endtask

    initial begin
        rst = 1'b1; startgame = 1'b0; stoptimer = 1'b0; yes = 1'b0; no = 1'b0;
        endtime = 1'b0; who = '0; maxuser = 4'd4; scorejia = '0; scorejian = '0;
        for (int k = 0; k < NP; k++) mscore[k] = 10;
        step();
        step();
        rst = 1'b0;
        check_scores("reset");
        check("reset_busy", busy, 0);
        check("reset_rv", result_valid, 0);
        check("reset_ok", result_ok, 0);
        check("reset_err", err, 0);
        check("reset_leader", leader, 0);
        check("reset_cur", cur_player, 0);

        do_round(4'b0100, 4'd4, 4'd3, 4'd0, 0);
        check("p2_is_13", score_of(2), 13);
        check("leader_is_2", leader, 2);

        for (int r = 0; r < 5; r++) do_round(4'b0001, 4'd4, 4'd15, 4'd0, 0);
        do_round(4'b0001, 4'd4, 4'd13, 4'd0, 0);
        check("p0_is_98", score_of(0), 98);
        do_round(4'b0001, 4'd4, 4'd5, 4'd0, 0);
        check("p0_sat_99", score_of(0), 99);

        do_round(4'b0010, 4'd4, 4'd0, 4'd8, 1);
        check("p1_is_2", score_of(1), 2);
        do_round(4'b0010, 4'd4, 4'd0, 4'd4, 1);
        check("p1_sat_0", score_of(1), 0);

        do_round(4'b0011, 4'd4, 4'd1, 4'd1, 0);
        do_round(4'b1000, 4'd3, 4'd1, 4'd1, 0);
        do_round(4'b0100, 4'd4, 4'd1, 4'd1, 3);

        do_round(4'b1000, 4'd4, 4'd0, 4'd2, 2);
        check("p3_timeout", score_of(3), TO_EN ? 8 : 10);

        maxuser = 4'd4; who = 4'b0001; stoptimer = 1'b1;
        step();
        stoptimer = 1'b0;
        check("sg_busy_pre", busy, 1);
        yes = 1'b1; startgame = 1'b1; scorejia = 4'd7;
        step();
        yes = 1'b0; startgame = 1'b0;
        for (int k = 0; k < NP; k++) mscore[k] = 10;
        check("sg_busy", busy, 0);
        check("sg_rv", result_valid, 0);
        check_scores("startgame");
        step();
        check("sg_rv2", result_valid, 0);
        check("sg_leader", leader, 0);

        for (int r = 0; r < 60; r++) begin
            logic [3:0] w;
            yes = 1'($urandom_range(0, 1));
            no = 1'($urandom_range(0, 1));
            endtime = 1'($urandom_range(0, 1));
            step();
            yes = 1'b0; no = 1'b0; endtime = 1'b0;
            check("idle_ignore_busy", busy, 0);
            check("idle_ignore_rv", result_valid, 0);
            check("idle_ignore_err", err, 0);
            if ($urandom_range(0, 3) == 0) w = 4'($urandom);
            else w = 4'(1 << $urandom_range(0, 3));
            do_round(w, 4'($urandom_range(1, 4)), 4'($urandom), 4'($urandom),
                     int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
